// File: rtl/cplx_mult_conj_pipe.sv
// cplx_mult_conj_pipe
//   Fully pipelined fixed-point complex multiplier with per-transaction
//   conjugation select. Each result carries round-half-up rounding,
//   saturation and an overflow flag. Latency is 3 ce-enabled cycles and
//   throughput is one transaction per cycle, with no backpressure.
//
// Ports
//   clk, rst          rising-edge clock, asynchronous active-high reset
//   ce                clock enable; low freezes every register
//   in_valid/A/B      operand pair, each packed {real[2W-1:W], imag[W-1:0]}
//   mode              00 A*B, 01 conj(A)*B, 10 A*conj(B), 11 conj(A)*conj(B)
//   in_tag            user tag, returned with the result
//   result            product {real, imag} in the W-bit FRAC format
//   out_valid         result/out_tag/ovf valid this cycle
//   out_tag           tag of the transaction in result
//   ovf               real or imag part saturated

// Per-lane round + saturate on a (2W+1)-bit sum.
module cmx_rnd_sat #(
  parameter int W    = 16,
  parameter int FRAC = 15
) (
  input  logic signed [2*W:0] x,
  output logic [W-1:0]        y,
  output logic                sat
);
  localparam int XW = 2*W + 2;  // one guard bit so adding the rounding constant cannot wrap
  localparam logic signed [XW-1:0] RND  = {{(XW-1){1'b0}}, 1'b1} << (FRAC-1);
  localparam logic signed [XW-1:0] MAXV = {{(W+3){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [XW-1:0] MINV = {{(W+3){1'b1}}, {(W-1){1'b0}}};

  logic signed [XW-1:0] xe, rs;
  assign xe = {x[2*W], x};
  assign rs = (xe + RND) >>> FRAC;

  always_comb begin
    y   = rs[W-1:0];
    sat = 1'b0;
    if (rs > MAXV) begin
      y   = {1'b0, {(W-1){1'b1}}};
      sat = 1'b1;
    end else if (rs < MINV) begin
      y   = {1'b1, {(W-1){1'b0}}};
      sat = 1'b1;
    end
  end
endmodule

module cplx_mult_conj_pipe #(
  parameter int W     = 16,
  parameter int FRAC  = 15,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ce,
  input  logic             in_valid,
  input  logic [2*W-1:0]   A,
  input  logic [2*W-1:0]   B,
  input  logic [1:0]       mode,
  input  logic [TAG_W-1:0] in_tag,
  output logic [2*W-1:0]   result,
  output logic             out_valid,
  output logic [TAG_W-1:0] out_tag,
  output logic             ovf
);
  localparam int STAGES = 3;
  localparam int PW     = 2*W;
  localparam int SW     = 2*W + 1;

  logic [STAGES:0] vld_pipe;
  assign vld_pipe[0] = in_valid;

  always_ff @(posedge clk or posedge rst)
    if (rst)     vld_pipe[STAGES:1] <= '0;
    else if (ce) vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];

  assign out_valid = vld_pipe[STAGES];

  // ---- stage 1: four partial products, conj flags, tag
  logic signed [W-1:0] ar, ai, br, bi;
  assign ar = A[2*W-1:W];
  assign ai = A[W-1:0];
  assign br = B[2*W-1:W];
  assign bi = B[W-1:0];

  logic signed [PW-1:0] p_rr, p_ii, p_ri, p_ir;
  logic                 s1_ca, s1_cb;
  logic [TAG_W-1:0]     s1_tag;

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      p_rr <= '0; p_ii <= '0; p_ri <= '0; p_ir <= '0;
      s1_ca <= 1'b0; s1_cb <= 1'b0; s1_tag <= '0;
    end else if (ce && vld_pipe[0]) begin
      p_rr   <= ar * br;
      p_ii   <= ai * bi;
      p_ri   <= ar * bi;
      p_ir   <= ai * br;
      s1_ca  <= mode[0];
      s1_cb  <= mode[1];
      s1_tag <= in_tag;
    end

  // ---- stage 2: conjugation applied as sign on products, so the
  // most-negative operand never has to be negated at W bits.
  logic signed [SW-1:0] x_rr, x_ii, x_ri, x_ir, re_n, im_n;
  assign x_rr = {p_rr[PW-1], p_rr};
  assign x_ii = {p_ii[PW-1], p_ii};
  assign x_ri = {p_ri[PW-1], p_ri};
  assign x_ir = {p_ir[PW-1], p_ir};

  always_comb begin
    re_n = (s1_ca ^ s1_cb) ? (x_rr + x_ii) : (x_rr - x_ii);
    im_n = (s1_cb ? -x_ri : x_ri) + (s1_ca ? -x_ir : x_ir);
  end

  // lane 1 = real, lane 0 = imag, matching the {real, imag} packing
  logic [1:0][SW-1:0] s2_sum;
  logic [TAG_W-1:0]   s2_tag;

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      s2_sum <= '0;
      s2_tag <= '0;
    end else if (ce && vld_pipe[1]) begin
      s2_sum <= {re_n, im_n};
      s2_tag <= s1_tag;
    end

  // ---- stage 3: round, saturate, register outputs
  logic [1:0][W-1:0] lane_y;
  logic [1:0]        lane_sat;

  for (genvar g = 0; g < 2; g++) begin : g_lane
    cmx_rnd_sat #(.W(W), .FRAC(FRAC)) u_rs (
      .x   (s2_sum[g]),
      .y   (lane_y[g]),
      .sat (lane_sat[g])
    );
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      result  <= '0;
      out_tag <= '0;
      ovf     <= 1'b0;
    end else if (ce && vld_pipe[2]) begin
      result  <= lane_y;
      out_tag <= s2_tag;
      ovf     <= |lane_sat;
    end
endmodule

// File: tb/tb_cplx_mult_conj_pipe.sv
module tb_cplx_mult_conj_pipe;
  localparam int W = 16, FRAC = 15, TAG_W = 4;

  logic             clk = 1'b0, rst = 1'b1, ce = 1'b1, in_valid = 1'b0;
  logic [2*W-1:0]   A = '0, B = '0;
  logic [1:0]       mode = '0;
  logic [TAG_W-1:0] in_tag = '0;
  logic [2*W-1:0]   result;
  logic             out_valid, ovf;
  logic [TAG_W-1:0] out_tag;

  int nvec = 0, nfail = 0;

  cplx_mult_conj_pipe #(.W(W), .FRAC(FRAC), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst), .ce(ce), .in_valid(in_valid), .A(A), .B(B),
    .mode(mode), .in_tag(in_tag), .result(result), .out_valid(out_valid),
    .out_tag(out_tag), .ovf(ovf)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1, "watchdog");
  end

  task automatic step;
    @(posedge clk); #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] b,
                       input logic [1:0] m, input logic [3:0] t);
    in_valid = v; A = a; B = b; mode = m; in_tag = t;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    step; step;
    nvec++;
    if (out_valid !== 1'b0 || result !== 32'h0 || out_tag !== 4'h0 || ovf !== 1'b0) begin
      nfail++;
      $display("FAIL reset_state: got v=%b res=%h tag=%h ovf=%b, want v=0 res=00000000 tag=0 ovf=0",
               out_valid, result, out_tag, ovf);
    end
    #3 rst = 1'b0;
    step;
  endtask

  task automatic test_modes;
    logic [31:0] er [4];
    er[0] = 32'h4000_0000; er[1] = 32'h0000_C000;
    er[2] = 32'h0000_4000; er[3] = 32'h4000_0000;
    for (int c = 0; c < 7; c++) begin
      if (c < 4) drive(1'b1, 32'h4000_4000, 32'h4000_C000, 2'(c), 4'(c + 1));
      else       drive(1'b0, 32'h0, 32'h0, 2'b00, 4'h0);
      step;
      if (c >= 2 && c <= 5) begin
        nvec++;
        if (out_valid !== 1'b1 || result !== er[c-2] || out_tag !== 4'(c - 1) || ovf !== 1'b0) begin
          nfail++;
          $display("FAIL modes_m%0d: got v=%b res=%h tag=%h ovf=%b, want v=1 res=%h tag=%h ovf=0",
                   c - 2, out_valid, result, out_tag, ovf, er[c-2], 4'(c - 1));
        end
      end else if (c == 6) begin
        nvec++;
        if (out_valid !== 1'b0) begin
          nfail++;
          $display("FAIL modes_tail: got v=%b, want v=0", out_valid);
        end
      end
    end
  endtask

  task automatic test_rounding;
    drive(1'b1, 32'h0001_0000, 32'h4000_0000, 2'b00, 4'h5); step;
    drive(1'b1, 32'hFFFF_0000, 32'h4000_0000, 2'b00, 4'h6); step;
    drive(1'b0, 32'h0, 32'h0, 2'b00, 4'h0); step;
    nvec++;
    if (out_valid !== 1'b1 || result !== 32'h0001_0000 || out_tag !== 4'h5 || ovf !== 1'b0) begin
      nfail++;
      $display("FAIL round_pos_half: got v=%b res=%h tag=%h ovf=%b, want v=1 res=00010000 tag=5 ovf=0",
               out_valid, result, out_tag, ovf);
    end
    step;
    nvec++;
    if (out_valid !== 1'b1 || result !== 32'h0000_0000 || out_tag !== 4'h6 || ovf !== 1'b0) begin
      nfail++;
      $display("FAIL round_neg_half: got v=%b res=%h tag=%h ovf=%b, want v=1 res=00000000 tag=6 ovf=0",
               out_valid, result, out_tag, ovf);
    end
    step;
  endtask

  task automatic test_bubbles;
    drive(1'b1, 32'h2000_0000, 32'h2000_0000, 2'b00, 4'h7); step;
    drive(1'b0, 32'h7FFF_7FFF, 32'h7FFF_7FFF, 2'b11, 4'hF); step;
    drive(1'b1, 32'h0000_2000, 32'h2000_0000, 2'b00, 4'h8); step;
    drive(1'b0, 32'h0, 32'h0, 2'b00, 4'h0);
    nvec++;
    if (out_valid !== 1'b1 || result !== 32'h0800_0000 || out_tag !== 4'h7) begin
      nfail++;
      $display("FAIL bubble_first: got v=%b res=%h tag=%h, want v=1 res=08000000 tag=7",
               out_valid, result, out_tag);
    end
    step;
    nvec++;
    if (out_valid !== 1'b0 || result !== 32'h0800_0000 || out_tag !== 4'h7) begin
      nfail++;
      $display("FAIL bubble_gap: got v=%b res=%h tag=%h, want v=0 res=08000000 tag=7",
               out_valid, result, out_tag);
    end
    step;
    nvec++;
    if (out_valid !== 1'b1 || result !== 32'h0000_0800 || out_tag !== 4'h8) begin
      nfail++;
      $display("FAIL bubble_second: got v=%b res=%h tag=%h, want v=1 res=00000800 tag=8",
               out_valid, result, out_tag);
    end
    step;
  endtask

  task automatic test_ce_stall;
    drive(1'b1, 32'h4000_0000, 32'h2000_0000, 2'b00, 4'h1); step;
    ce = 1'b0;
    drive(1'b1, 32'h7FFF_7FFF, 32'h7FFF_7FFF, 2'b01, 4'hE);
    for (int i = 0; i < 5; i++) begin
      step;
      nvec++;
      if (out_valid !== 1'b0 || result !== 32'h0000_0800 || out_tag !== 4'h8) begin
        nfail++;
        $display("FAIL stall1_c%0d: got v=%b res=%h tag=%h, want v=0 res=00000800 tag=8",
                 i, out_valid, result, out_tag);
      end
    end
    ce = 1'b1;
    drive(1'b1, 32'h0000_4000, 32'h0000_4000, 2'b00, 4'h2); step;
    drive(1'b1, 32'h4000_0000, 32'h0000_4000, 2'b00, 4'h3); step;
    nvec++;
    if (out_valid !== 1'b1 || result !== 32'h1000_0000 || out_tag !== 4'h1) begin
      nfail++;
      $display("FAIL stall_tx1: got v=%b res=%h tag=%h, want v=1 res=10000000 tag=1",
               out_valid, result, out_tag);
    end
    // freeze again while a result is being presented
    ce = 1'b0;
    drive(1'b1, 32'h7FFF_7FFF, 32'h7FFF_7FFF, 2'b10, 4'hD);
    for (int i = 0; i < 2; i++) begin
      step;
      nvec++;
      if (out_valid !== 1'b1 || result !== 32'h1000_0000 || out_tag !== 4'h1) begin
        nfail++;
        $display("FAIL stall2_c%0d: got v=%b res=%h tag=%h, want v=1 res=10000000 tag=1",
                 i, out_valid, result, out_tag);
      end
    end
    ce = 1'b1;
    drive(1'b0, 32'h0, 32'h0, 2'b00, 4'h0); step;
    nvec++;
    if (out_valid !== 1'b1 || result !== 32'hE000_0000 || out_tag !== 4'h2) begin
      nfail++;
      $display("FAIL stall_tx2: got v=%b res=%h tag=%h, want v=1 res=E0000000 tag=2",
               out_valid, result, out_tag);
    end
    step;
    nvec++;
    if (out_valid !== 1'b1 || result !== 32'h0000_2000 || out_tag !== 4'h3) begin
      nfail++;
      $display("FAIL stall_tx3: got v=%b res=%h tag=%h, want v=1 res=00002000 tag=3",
               out_valid, result, out_tag);
    end
    step;
    nvec++;
    if (out_valid !== 1'b0) begin
      nfail++;
      $display("FAIL stall_no_capture: got v=%b, want v=0", out_valid);
    end
  endtask

  task automatic test_saturation;
    drive(1'b1, 32'h8000_0000, 32'h8000_0000, 2'b00, 4'h9); step;
    drive(1'b1, 32'h8000_8000, 32'h8000_7FFF, 2'b00, 4'hA); step;
    drive(1'b0, 32'h0, 32'h0, 2'b00, 4'h0); step;
    nvec++;
    if (out_valid !== 1'b1 || result !== 32'h7FFF_0000 || out_tag !== 4'h9 || ovf !== 1'b1) begin
      nfail++;
      $display("FAIL sat_minsq: got v=%b res=%h tag=%h ovf=%b, want v=1 res=7FFF0000 tag=9 ovf=1",
               out_valid, result, out_tag, ovf);
    end
    step;
    nvec++;
    if (out_valid !== 1'b1 || result !== 32'h7FFF_0001 || out_tag !== 4'hA || ovf !== 1'b1) begin
      nfail++;
      $display("FAIL sat_real: got v=%b res=%h tag=%h ovf=%b, want v=1 res=7FFF0001 tag=A ovf=1",
               out_valid, result, out_tag, ovf);
    end
  endtask

  task automatic test_async_reset;
    drive(1'b1, 32'h4000_4000, 32'h4000_4000, 2'b00, 4'hB); step;
    drive(1'b1, 32'h2000_0000, 32'h2000_0000, 2'b00, 4'hC); step;
    drive(1'b0, 32'h0, 32'h0, 2'b00, 4'h0);
    #3 rst = 1'b1;
    #1;
    nvec++;
    if (out_valid !== 1'b0 || result !== 32'h0 || out_tag !== 4'h0 || ovf !== 1'b0) begin
      nfail++;
      $display("FAIL async_reset: got v=%b res=%h tag=%h ovf=%b, want v=0 res=00000000 tag=0 ovf=0",
               out_valid, result, out_tag, ovf);
    end
    step; step;
    #2 rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step;
      nvec++;
      if (out_valid !== 1'b0 || result !== 32'h0) begin
        nfail++;
        $display("FAIL reset_stale_c%0d: got v=%b res=%h, want v=0 res=00000000",
                 i, out_valid, result);
      end
    end
    drive(1'b1, 32'h0001_0000, 32'h4000_0000, 2'b00, 4'h4); step;
    drive(1'b0, 32'h0, 32'h0, 2'b00, 4'h0); step;
    nvec++;
    if (out_valid !== 1'b0) begin
      nfail++;
      $display("FAIL post_reset_early: got v=%b after 2 cycles, want v=0", out_valid);
    end
    step;
    nvec++;
    if (out_valid !== 1'b1 || result !== 32'h0001_0000 || out_tag !== 4'h4 || ovf !== 1'b0) begin
      nfail++;
      $display("FAIL post_reset_tx: got v=%b res=%h tag=%h ovf=%b, want v=1 res=00010000 tag=4 ovf=0",
               out_valid, result, out_tag, ovf);
    end
  endtask

  initial begin
    test_reset;
    test_modes;
    test_rounding;
    test_bubbles;
    test_ce_stall;
    test_saturation;
    test_async_reset;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end
endmodule
